// File: rtl/data_mem_unit.sv
// Data memory unit: word RAM, core flag registers, indirect pointer
// channels and a single-outstanding peripheral bus bridge with timeout.
module data_mem_unit #(
  parameter int DATA_W       = 16,
  parameter int MEM_AW       = 9,
  parameter int N_IND        = 2,
  parameter int PERI_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_bar,
  input  logic              req,
  input  logic              we,
  input  logic [10:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] wreg,
  input  logic              carry_in,
  input  logic              zero_in,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              carry_out,
  output logic              zero_out,
  output logic              interrupt,
  output logic [7:0]        peri_addr,
  output logic [DATA_W-1:0] peri_wdata,
  output logic              peri_we,
  output logic              peri_re,
  input  logic [DATA_W-1:0] peri_rdata,
  input  logic              peri_ack,
  input  logic              peri_irq
);

  localparam int DEPTH = 2**MEM_AW;
  localparam int IW = (N_IND > 1) ? $clog2(N_IND) : 1;
  localparam logic [DATA_W-1:0] DEAD = DATA_W'(16'hDEAD);
  localparam logic [7:0] TO_LAST = 8'(PERI_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [MEM_AW-1:0] ptr [N_IND];
  logic              inc_m [N_IND];
  logic              dec_m [N_IND];

  logic [7:0]        cnt;
  logic [DATA_W-1:0] pdata;
  logic              irq_en;
  logic              bus_err;

  logic              acc;
  logic              is_ram;
  logic              is_wreg;
  logic              is_carry;
  logic              is_zero;
  logic              is_irq;
  logic              is_indv;
  logic              is_inda;
  logic              is_peri;
  logic [IW-1:0]     ind_sel;
  logic [MEM_AW-1:0] ind_ptr;
  logic [MEM_AW-1:0] ptr_step;
  logic [MEM_AW-1:0] ram_a;
  logic              ram_we;
  logic [DATA_W-1:0] inda_val;
  logic [DATA_W-1:0] rd_val;

  assign acc  = req & (state == S_IDLE);
  assign busy = (state != S_IDLE);

  always_comb begin
    is_ram   = int'(addr) < DEPTH;
    is_wreg  = (addr == 11'h200);
    is_carry = (addr == 11'h201);
    is_zero  = (addr == 11'h202);
    is_irq   = (addr == 11'h203);
    is_peri  = (addr[10:8] == 3'b011);
    is_indv  = 1'b0;
    is_inda  = 1'b0;
    ind_sel  = '0;
    for (int k = 0; k < N_IND; k++) begin
      if (addr == 11'(12'h208 + 2 * k)) begin
        is_indv = 1'b1;
        ind_sel = IW'(k);
      end
      if (addr == 11'(12'h209 + 2 * k)) begin
        is_inda = 1'b1;
        ind_sel = IW'(k);
      end
    end
  end

  // Both mode bits set cancels the auto-step.
  always_comb begin
    ind_ptr  = ptr[ind_sel];
    ptr_step = ind_ptr;
    if (inc_m[ind_sel] && !dec_m[ind_sel])
      ptr_step = ind_ptr + MEM_AW'(1);
    else if (dec_m[ind_sel] && !inc_m[ind_sel])
      ptr_step = ind_ptr - MEM_AW'(1);
  end

  always_comb begin
    inda_val = '0;
    inda_val[MEM_AW-1:0] = ind_ptr;
    inda_val[DATA_W-1]   = inc_m[ind_sel];
    inda_val[DATA_W-2]   = dec_m[ind_sel];
  end

  assign ram_a  = is_indv ? ind_ptr : addr[MEM_AW-1:0];
  assign ram_we = acc & we & (is_ram | is_indv);

  always_comb begin
    rd_val = DEAD;
    unique case (1'b1)
      is_ram, is_indv: rd_val = mem[ram_a];
      is_wreg:         rd_val = wreg;
      is_carry:        rd_val = DATA_W'(carry_out);
      is_zero:         rd_val = DATA_W'(zero_out);
      is_irq:          rd_val = DATA_W'({bus_err, irq_en, peri_irq});
      is_inda:         rd_val = inda_val;
      default:         rd_val = DEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ram_a] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (acc && is_peri) state_n = S_WAIT;
      S_WAIT:  if (peri_ack || cnt == TO_LAST) state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      cnt        <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      pdata      <= '0;
      peri_addr  <= '0;
      peri_wdata <= '0;
      peri_we    <= 1'b0;
      peri_re    <= 1'b0;
      carry_out  <= 1'b0;
      zero_out   <= 1'b0;
      interrupt  <= 1'b0;
      irq_en     <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      rvalid    <= 1'b0;
      carry_out <= (acc & we & is_carry) ? wdata[0] : carry_in;
      zero_out  <= (acc & we & is_zero) ? wdata[0] : zero_in;
      interrupt <= irq_en & (peri_irq | bus_err);
      if (acc && we && is_irq) begin
        irq_en <= wdata[1];
        if (wdata[2])
          bus_err <= 1'b0;
      end
      if (acc && !is_peri) begin
        rvalid <= 1'b1;
        if (!we)
          rdata <= rd_val;
      end
      if (acc && is_peri) begin
        peri_addr  <= addr[7:0];
        peri_wdata <= wdata;
        peri_we    <= we;
        peri_re    <= ~we;
        cnt        <= '0;
      end
      // An ack in the final wait cycle takes priority over the timeout.
      if (state == S_WAIT) begin
        if (peri_ack) begin
          pdata   <= peri_rdata;
          peri_we <= 1'b0;
          peri_re <= 1'b0;
        end else if (cnt == TO_LAST) begin
          pdata   <= DEAD;
          bus_err <= 1'b1;
          peri_we <= 1'b0;
          peri_re <= 1'b0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
      if (state == S_RESP) begin
        rvalid <= 1'b1;
        rdata  <= pdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      for (int k = 0; k < N_IND; k++) begin
        ptr[k]   <= '0;
        inc_m[k] <= 1'b0;
        dec_m[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < N_IND; k++) begin
        if (acc && ind_sel == IW'(k)) begin
          if (is_indv) begin
            ptr[k] <= ptr_step;
          end else if (is_inda && we) begin
            ptr[k]   <= wdata[MEM_AW-1:0];
            inc_m[k] <= wdata[DATA_W-1];
            dec_m[k] <= wdata[DATA_W-2];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Testbench for data_mem_unit: directed scenarios plus randomized
// RAM/indirect traffic against an array-based reference model.
module tb_data_mem_unit;

  logic        clk;
  logic        reset_bar;
  logic        req;
  logic        we;
  logic [10:0] addr;
  logic [15:0] wdata;
  logic [15:0] wreg;
  logic        carry_in;
  logic        zero_in;
  logic [15:0] rdata;
  logic        rvalid;
  logic        busy;
  logic        carry_out;
  logic        zero_out;
  logic        interrupt;
  logic [7:0]  peri_addr;
  logic [15:0] peri_wdata;
  logic        peri_we;
  logic        peri_re;
  logic [15:0] peri_rdata;
  logic        peri_ack;
  logic        peri_irq;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] mm [512];
  int          mp [2];
  bit          minc [2];
  bit          mdec [2];

  data_mem_unit dut (
    .clk        (clk),
    .reset_bar  (reset_bar),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .wreg       (wreg),
    .carry_in   (carry_in),
    .zero_in    (zero_in),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .busy       (busy),
    .carry_out  (carry_out),
    .zero_out   (zero_out),
    .interrupt  (interrupt),
    .peri_addr  (peri_addr),
    .peri_wdata (peri_wdata),
    .peri_we    (peri_we),
    .peri_re    (peri_re),
    .peri_rdata (peri_rdata),
    .peri_ack   (peri_ack),
    .peri_irq   (peri_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; samples the cycle after accept.
  task automatic access(input logic w, input logic [10:0] a,
                        input logic [15:0] d,
                        output logic [15:0] r, output logic v);
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    r = rdata;
    v = rvalid;
  endtask

  task automatic wr(input string tag, input logic [10:0] a,
                    input logic [15:0] d);
    logic [15:0] r;
    logic v;
    access(1'b1, a, d, r, v);
    chk({tag, "_rv"}, v, 1);
  endtask

  task automatic rd(input string tag, input logic [10:0] a,
                    input logic [15:0] exp);
    logic [15:0] r;
    logic v;
    access(1'b0, a, 16'h0, r, v);
    chk({tag, "_rv"}, v, 1);
    chk(tag, r, exp);
  endtask

  task automatic peri_txn(input logic w, input logic [10:0] a,
                          input logic [15:0] d, input int ack_at,
                          input logic [15:0] ack_d, input logic inject,
                          output int nbusy, output logic [15:0] r,
                          output logic v, output logic stable,
                          output logic [7:0] pa1, output logic re1,
                          output logic we1);
    logic done;
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    nbusy = 0;
    r = '0;
    v = 1'b0;
    stable = 1'b1;
    done = 1'b0;
    pa1 = peri_addr;
    re1 = peri_re;
    we1 = peri_we;
    for (int i = 1; i <= 100 && !done; i++) begin
      if (busy) begin
        nbusy++;
        if (peri_re || peri_we)
          stable = stable && peri_addr == a[7:0] && peri_we == w &&
                   peri_re == !w && peri_wdata == d;
        peri_ack = (i == ack_at);
        peri_rdata = (i == ack_at) ? ack_d : 16'h0;
        if (inject && i == 2) begin
          req = 1'b1;
          we = 1'b1;
          addr = 11'h007;
          wdata = 16'hFFFF;
        end else begin
          req = 1'b0;
        end
        @(negedge clk);
      end else begin
        r = rdata;
        v = rvalid;
        done = 1'b1;
      end
    end
    peri_ack = 1'b0;
    req = 1'b0;
    chk("peri_done_in_bound", done, 1);
  endtask

  function automatic int stepp(int p, bit i, bit d);
    if (i && !d) return (p + 1) % 512;
    if (d && !i) return (p + 511) % 512;
    return p;
  endfunction

  initial begin
    logic [15:0] r;
    logic        v;
    logic        st;
    logic        mon;
    logic [7:0]  pa;
    logic        pre;
    logic        pwe;
    int          nb;
    int          k;
    int          op;
    logic [10:0] a;
    logic [15:0] d;

    reset_bar = 1'b1;
    req = 1'b0;
    we = 1'b0;
    addr = '0;
    wdata = '0;
    wreg = 16'h5A5A;
    carry_in = 1'b0;
    zero_in = 1'b0;
    peri_rdata = '0;
    peri_ack = 1'b0;
    peri_irq = 1'b0;
    #1 reset_bar = 1'b0;
    #1;
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_peri_we", peri_we, 0);
    chk("rst_peri_re", peri_re, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_zero", zero_out, 0);
    chk("rst_irq", interrupt, 0);
    @(negedge clk);
    @(negedge clk);
    reset_bar = 1'b1;
    @(negedge clk);

    wr("ram_wr5", 11'h005, 16'h1234);
    mm[5] = 16'h1234;
    rd("ram_rd5", 11'h005, 16'h1234);
    @(negedge clk);
    chk("rvalid_pulse", rvalid, 0);

    wr("inda0_wr", 11'h209, 16'h81FF);
    wr("indv0_wr1", 11'h208, 16'hAAAA);
    wr("indv0_wr2", 11'h208, 16'hAAAA);
    mm[511] = 16'hAAAA;
    mm[0] = 16'hAAAA;
    rd("ram_1ff", 11'h1FF, 16'hAAAA);
    rd("ram_000", 11'h000, 16'hAAAA);
    rd("inda0_rd", 11'h209, 16'h8001);

    carry_in = 1'b0;
    wr("carry_wr", 11'h201, 16'h0001);
    chk("carry_after_wr", carry_out, 1);
    @(negedge clk);
    chk("carry_reload", carry_out, 0);
    zero_in = 1'b1;
    @(negedge clk);
    chk("zero_follow", zero_out, 1);
    zero_in = 1'b0;
    carry_in = 1'b1;
    @(negedge clk);
    rd("carry_rd", 11'h201, 16'h0001);
    carry_in = 1'b0;
    rd("unmapped_250", 11'h250, 16'hDEAD);
    rd("unmapped_600", 11'h600, 16'hDEAD);
    rd("wreg_rd", 11'h200, 16'h5A5A);

    peri_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stray_ack_busy", busy, 0);
    chk("stray_ack_rv", rvalid, 0);
    peri_ack = 1'b0;

    peri_txn(1'b0, 11'h310, 16'h0, 3, 16'hBEEF, 1'b0,
             nb, r, v, st, pa, pre, pwe);
    chk("p38_addr", pa, 8'h10);
    chk("p38_re", pre, 1);
    chk("p38_we", pwe, 0);
    chk("p38_busy", nb, 4);
    chk("p38_stable", st, 1);
    chk("p38_rv", v, 1);
    chk("p38_rdata", r, 16'hBEEF);

    wr("ram_wr7", 11'h007, 16'h0707);
    mm[7] = 16'h0707;
    peri_txn(1'b1, 11'h320, 16'h1111, 0, 16'h0, 1'b1,
             nb, r, v, st, pa, pre, pwe);
    chk("p39_we", pwe, 1);
    chk("p39_re", pre, 0);
    chk("p39_busy", nb, 16);
    chk("p39_stable", st, 1);
    chk("p39_rv", v, 1);
    chk("p39_rdata", r, 16'hDEAD);
    rd("busy_req_ignored", 11'h007, 16'h0707);
    rd("irqctl_err", 11'h203, 16'h0004);
    chk("irq_disabled", interrupt, 0);
    wr("irqctl_en", 11'h203, 16'h0002);
    chk("irq_latency", interrupt, 0);
    @(negedge clk);
    chk("irq_on", interrupt, 1);
    wr("irqctl_clr", 11'h203, 16'h0006);
    @(negedge clk);
    chk("irq_cleared", interrupt, 0);
    rd("irqctl_after_clr", 11'h203, 16'h0002);
    peri_irq = 1'b1;
    @(negedge clk);
    chk("irq_peri", interrupt, 1);
    rd("irqctl_peri", 11'h203, 16'h0003);
    peri_irq = 1'b0;
    wr("irqctl_off", 11'h203, 16'h0000);

    req = 1'b1;
    we = 1'b0;
    addr = 11'h340;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("p41_busy", busy, 1);
    chk("p41_re", peri_re, 1);
    @(negedge clk);
    #2 reset_bar = 1'b0;
    #1;
    chk("p41_rst_busy", busy, 0);
    chk("p41_rst_re", peri_re, 0);
    chk("p41_rst_we", peri_we, 0);
    chk("p41_rst_rv", rvalid, 0);
    mon = 1'b0;
    repeat (2) begin
      @(negedge clk);
      mon = mon | rvalid;
    end
    reset_bar = 1'b1;
    repeat (3) begin
      @(negedge clk);
      mon = mon | rvalid | busy;
    end
    chk("p41_no_rvalid", mon, 0);
    rd("p41_ram5", 11'h005, 16'h1234);
    rd("p41_ram1ff", 11'h1FF, 16'hAAAA);
    rd("p41_ptr_rst", 11'h209, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      mp[i] = 0;
      minc[i] = 1'b0;
      mdec[i] = 1'b0;
    end

    for (int i = 0; i < 512; i++) begin
      d = 16'($urandom);
      wr("fill", 11'(i), d);
      mm[i] = d;
    end

    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 6);
      k = $urandom_range(0, 1);
      d = 16'($urandom);
      case (op)
        0: begin
          a = 11'($urandom_range(0, 511));
          wr("rnd_ram_wr", a, d);
          mm[a] = d;
        end
        1: begin
          a = 11'($urandom_range(0, 511));
          rd("rnd_ram_rd", a, mm[a]);
        end
        2: begin
          wr("rnd_inda_wr", 11'(12'h209 + 2 * k), d);
          mp[k] = int'(d[8:0]);
          minc[k] = d[15];
          mdec[k] = d[14];
        end
        3: begin
          wr("rnd_indv_wr", 11'(12'h208 + 2 * k), d);
          mm[mp[k]] = d;
          mp[k] = stepp(mp[k], minc[k], mdec[k]);
        end
        4: begin
          rd("rnd_indv_rd", 11'(12'h208 + 2 * k), mm[mp[k]]);
          mp[k] = stepp(mp[k], minc[k], mdec[k]);
        end
        5: begin
          rd("rnd_inda_rd", 11'(12'h209 + 2 * k),
             {minc[k], mdec[k], 5'b0, 9'(mp[k])});
        end
        default: begin
          if (k == 0)
            a = 11'($urandom_range(12'h20C, 12'h2FF));
          else
            a = 11'($urandom_range(12'h400, 12'h7FF));
          if (d[0])
            wr("rnd_unmap_wr", a, d);
          else
            rd("rnd_unmap_rd", a, 16'hDEAD);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter DATA_W, default 16, data word width in bits (8..32).
REQ-002 Parameter MEM_AW, default 9, RAM address width; depth = 2**MEM_AW words (MEM_AW <= 9).
REQ-003 Parameter N_IND, default 2, number of indirect pointer channels (1..4).
REQ-004 Parameter PERI_TIMEOUT, default 15, maximum cycles waiting for peri_ack (1..255).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_bar  input  1  reset, asynchronous, active-low.
REQ-007 req  input  1  access request; accepted on a rising edge when busy=0.
REQ-008 we  input  1  1=write, 0=read; sampled with req.
REQ-009 addr  input  11  word address.
REQ-010 wdata  input  DATA_W  write data.
REQ-011 wreg, carry_in, zero_in  input  DATA_W,1,1  core W register and ALU flags.
REQ-012 rdata  output  DATA_W  read data, valid only while rvalid=1.
REQ-013 rvalid  output  1  one-cycle read/complete pulse.
REQ-014 busy  output  1  1 while a peripheral transaction is outstanding.
REQ-015 carry_out, zero_out, interrupt  output  1 each  flag registers and gated interrupt.
REQ-016 peri_addr, peri_wdata, peri_we, peri_re  output  8,DATA_W,1,1  peripheral bus request.
REQ-017 peri_rdata, peri_ack, peri_irq  input  DATA_W,1,1  peripheral bus response and IRQ.

Function
REQ-018 Map: 0x000..2**MEM_AW-1 RAM; 0x200 WREG (RO); 0x201 CARRY; 0x202 ZERO; 0x203 IRQCTL; 0x208+2k INDV[k]; 0x209+2k INDA[k], k<N_IND; 0x300..0x3FF peripheral; all else unmapped.
REQ-019 Unmapped: reads return 0xDEAD truncated to DATA_W, writes ignored; unimplemented channels k>=N_IND are unmapped.
REQ-020 RAM is single-port synchronous: write at the accepting edge; read data on rdata with rvalid=1 exactly one cycle after accept.
REQ-021 TIP and unmapped accesses also complete with rvalid one cycle after accept (writes included).
REQ-022 INDA[k] layout: bits[MEM_AW-1:0] pointer, bit DATA_W-1 auto-increment, bit DATA_W-2 auto-decrement; other bits read 0; both mode bits set means no auto-step.
REQ-023 INDV[k] access reads/writes RAM at pointer[k]; after the access the pointer steps +1/-1 per mode, wrapping modulo 2**MEM_AW.
REQ-024 A direct RAM write and an INDV access never occur in the same cycle (one request per cycle).
REQ-025 carry/zero registers load carry_in/zero_in every cycle, except a CARRY/ZERO write loads wdata[0]; carry_out/zero_out drive those registers directly.
REQ-026 IRQCTL: bit0 peri_irq (RO), bit1 irq_en (RW), bit2 bus_err (sticky, write-1-to-clear).
REQ-027 interrupt is registered: interrupt <= irq_en & (peri_irq | bus_err), one cycle latency.
REQ-028 Peripheral FSM states IDLE, WAIT, RESP; busy = (state != IDLE).
REQ-029 IDLE + accepted peripheral access -> WAIT; peri_addr=addr[7:0], peri_wdata=wdata, peri_we=we, peri_re=~we, all held stable through WAIT.
REQ-030 WAIT + peri_ack -> RESP, capture peri_rdata, drop strobes; RESP -> IDLE with rvalid=1 and captured data.
REQ-031 WAIT counter counts cycles from entry; at PERI_TIMEOUT without ack -> RESP with rdata=0xDEAD, bus_err set; ack arriving in the timeout cycle wins.
REQ-032 req while busy=1 is ignored, not queued.
REQ-033 peri_ack outside WAIT is ignored.

Reset
REQ-034 reset_bar=0 asynchronously: FSM IDLE, counter 0, rdata 0, rvalid, busy, peri_we, peri_re, carry_out, zero_out, interrupt, irq_en, bus_err all 0, all pointers and mode bits 0.
REQ-035 Reset mid-transaction drops strobes immediately and produces no rvalid; RAM contents are not cleared.

Verification
REQ-036 Write 0x1234 to 0x005, read 0x005 -> rvalid one cycle after accept with rdata=0x1234.
REQ-037 INDA[0]=0x8000|0x1FF, write INDV[0]=0xAAAA twice -> RAM[0x1FF]=0xAAAA, RAM[0x000]=0xAAAA, pointer reads 0x001.
REQ-038 Peripheral read 0x310, ack 3 cycles later with 0xBEEF -> peri_addr=0x10, busy 4 cycles, rdata=0xBEEF with rvalid.
REQ-039 Peripheral write, no ack -> after 15 WAIT cycles rdata=0xDEAD, bus_err=1; irq_en=1 -> interrupt=1 next cycle; write IRQCTL=0x6 -> bus_err=0.
REQ-040 Write CARRY=1 with carry_in=0 -> carry_out=1 after that edge, 0 on the following edge; read 0x250 -> 0xDEAD.
REQ-041 Assert reset_bar=0 during WAIT -> peri_re/peri_we/busy 0 immediately, no rvalid, prior RAM data intact.
